risc_pc_unit: RTL and testbench
===============================

// Module: risc_pc_unit
// PURPOSE
//  Parametrised program-counter / next-PC unit for the RISC-V core front end.
//  Holds the fetch address and presents it to instruction memory over a valid/ready handshake.
//  Redirects (branch, JALR, trap) that arrive while a fetch is stalled are buffered.
//  A misaligned branch/jump target raises a fault, and the unit parks until a trap redirect.
// PARAMETERS
//  XLEN          32  address/data width
//  RESET_VECTOR  0   fetch address loaded on reset
//  OFFSET_SHIFT  1   left shift applied to br_offset (RISC-V B-imm is halfword-scaled)
//  ALIGN_BYTES   4   required target alignment; legal values 2 or 4
// PORTS
//  clk             in   1     rising-edge clock
//  rst             in   1     asynchronous, active-high reset
//  fetch_addr      out  XLEN  current fetch PC
//  fetch_valid     out  1     fetch_addr is a valid request
//  fetch_ready     in   1     imem accepts request; fire = fetch_valid & fetch_ready
//  pc_link         out  XLEN  fetch_addr + 4, mod 2^XLEN (link value for JAL/JALR)
//  br_taken        in   1     branch/JAL taken, relative to fetch_addr
//  br_offset       in   XLEN  sign-extended offset, pre-shift
//  jr_taken        in   1     JALR taken
//  jr_target       in   XLEN  JALR target; bit 0 forced to 0
//  trap_req        in   1     trap redirect
//  trap_vector     in   XLEN  trap target; low 2 bits forced to 0
//  redirect_pending out 1     a buffered redirect awaits the next fire
//  misalign_fault  out  1     one-cycle pulse on misaligned br/jr target
// BEHAVIOUR
//  Reset (async, any state): fetch_addr=RESET_VECTOR, state IDLE, fetch_valid=0,
//   pend_valid=0, redirect_pending=0, misalign_fault=0.
//  States:
//   IDLE  -> RUN on the first clock after reset release.
//   RUN   fetch_valid=1.
//   DRAIN fetch_valid=1; entered on misalignment while the request is unaccepted.
//         Goes to FAULT on fire.
//   FAULT fetch_valid=0.
//  Handshake: while fetch_valid & !fetch_ready, fetch_addr is held stable. PC changes only on fire,
//   except in FAULT.
//  Target select, priority trap > jr > br:
//   trap: trap_vector & ~3
//   jr:   jr_target & ~1
//   br:   fetch_addr + (br_offset << OFFSET_SHIFT), truncated to XLEN
//  Misalignment:
//   - Detected when a selected jr/br target has target % ALIGN_BYTES != 0. Trap targets are never checked.
//   - Response: misalign_fault=1 for exactly one cycle; redirect discarded; any pending redirect cleared.
//   - Next state: FAULT if fire occurs that cycle or fetch_valid=0, else DRAIN.
//  Next PC on fire (RUN):
//   - Redirect this cycle: its target (same-cycle redirect beats the pending one); pend cleared.
//   - Else pend_valid: pend_target; pend cleared.
//   - Else fetch_addr+4 (wraps 0xFFFF_FFFC -> 0 for XLEN=32).
//  Redirect without fire (RUN/DRAIN):
//   - Latched into pend_target and pend_valid=1; a newer redirect overwrites an older one.
//   - redirect_pending=pend_valid, registered.
//   - In DRAIN only trap_req is buffered; br/jr are ignored.
//  DRAIN with buffered trap: on fire, go to RUN at the trap target instead of FAULT.
//  FAULT: br/jr ignored. trap_req loads the trap target next cycle, and the state returns to RUN
//   with fetch_valid=1.
//  Latency: redirect to new fetch_addr is 1 cycle when fetch_ready=1; otherwise the first cycle after fire.
// TESTING
//  1. rst pulse, RESET_VECTOR=0, fetch_ready=1 -> cycle0 valid=0; then fetch_addr 0,4,8 with valid=1.
//  2. At 0x10, fetch_ready=0 for 3 cycles, br_taken offset 0x8 in cycle 1 -> addr held at 0x10,
//     redirect_pending=1; ready=1 -> next fetch_addr 0x20, pending=0.
//  3. Same cycle: trap_req vector 0x103, br_taken, jr_taken, ready=1 -> next fetch_addr 0x100.
//  4. jr_target 0x1001 -> next addr 0x1000, no fault. br_offset 0x1 at 0x40, ALIGN_BYTES=4 ->
//     misalign_fault one cycle, FAULT, valid=0; trap_req 0x200 -> addr 0x200, valid=1.
//  5. fetch_addr 0xFFFF_FFFC, fire -> fetch_addr 0x0, pc_link 0x0 before the wrap cycle.
//  6. rst asserted mid-stall with a pending redirect -> immediately fetch_addr=RESET_VECTOR, valid=0,
//     pending=0, without waiting for a clock.

Source files
------------

// File: rtl/risc_pc_unit.sv
// rtl/risc_pc_unit.sv - program counter / next-PC unit with fetch handshake, redirect buffering and misalign parking
module risc_pc_unit #(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
    parameter int                OFFSET_SHIFT = 1,
    parameter int                ALIGN_BYTES  = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic [XLEN-1:0] o_fetch_addr,
    output logic            o_fetch_valid,
    input  logic            i_fetch_ready,
    output logic [XLEN-1:0] o_pc_link,
    input  logic            i_br_taken,
    input  logic [XLEN-1:0] i_br_offset,
    input  logic            i_jr_taken,
    input  logic [XLEN-1:0] i_jr_target,
    input  logic            i_trap_req,
    input  logic [XLEN-1:0] i_trap_vector,
    output logic            o_redirect_pending,
    output logic            o_misalign_fault
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ALIGN_BYTES - 1);
    localparam logic [XLEN-1:0] TRAP_MASK  = ~XLEN'(3);
    localparam logic [XLEN-1:0] JR_MASK    = ~XLEN'(1);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

    state_t          r_state;
    logic [XLEN-1:0] r_fetch_addr;
    logic            r_pend_valid;
    logic [XLEN-1:0] r_pend_target;
    logic            r_misalign_fault;

    state_t          w_next_state;
    logic [XLEN-1:0] w_next_addr;
    logic            w_next_pend_valid;
    logic [XLEN-1:0] w_next_pend_target;
    logic            w_misalign;

    logic            w_fetch_valid;
    logic            w_fire;
    logic [XLEN-1:0] w_trap_tgt;
    logic [XLEN-1:0] w_jr_tgt;
    logic [XLEN-1:0] w_br_tgt;
    logic            w_sel_valid;
    logic            w_sel_check;
    logic [XLEN-1:0] w_sel_target;
    logic            w_sel_bad;

    assign w_fetch_valid = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_fire        = w_fetch_valid && i_fetch_ready;
    assign w_trap_tgt    = i_trap_vector & TRAP_MASK;
    assign w_jr_tgt      = i_jr_target & JR_MASK;
    assign w_br_tgt      = r_fetch_addr + (i_br_offset << OFFSET_SHIFT);

    // Priority trap > jr > br; only jr/br targets are subject to the alignment check.
    always_comb begin
        w_sel_valid  = 1'b0;
        w_sel_check  = 1'b0;
        w_sel_target = w_br_tgt;
        if (i_trap_req) begin
            w_sel_valid  = 1'b1;
            w_sel_target = w_trap_tgt;
        end else if (i_jr_taken) begin
            w_sel_valid  = 1'b1;
            w_sel_check  = 1'b1;
            w_sel_target = w_jr_tgt;
        end else if (i_br_taken) begin
            w_sel_valid  = 1'b1;
            w_sel_check  = 1'b1;
        end
    end

    assign w_sel_bad = w_sel_check && ((w_sel_target & ALIGN_MASK) != '0);

    always_comb begin
        w_next_state       = r_state;
        w_next_addr        = r_fetch_addr;
        w_next_pend_valid  = r_pend_valid;
        w_next_pend_target = r_pend_target;
        w_misalign         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_next_state = ST_RUN;
            end
            ST_RUN: begin
                if (w_sel_valid && w_sel_bad) begin
                    w_misalign        = 1'b1;
                    w_next_pend_valid = 1'b0;
                    w_next_state      = w_fire ? ST_FAULT : ST_DRAIN;
                end else if (w_fire) begin
                    if (w_sel_valid)
                        w_next_addr = w_sel_target;
                    else if (r_pend_valid)
                        w_next_addr = r_pend_target;
                    else
                        w_next_addr = r_fetch_addr + PC_STEP;
                    w_next_pend_valid = 1'b0;
                end else if (w_sel_valid) begin
                    w_next_pend_valid  = 1'b1;
                    w_next_pend_target = w_sel_target;
                end
            end
            ST_DRAIN: begin
                // Only a trap can rescue the drain; otherwise park once the request is taken.
                if (w_fire) begin
                    w_next_pend_valid = 1'b0;
                    if (i_trap_req) begin
                        w_next_addr  = w_trap_tgt;
                        w_next_state = ST_RUN;
                    end else if (r_pend_valid) begin
                        w_next_addr  = r_pend_target;
                        w_next_state = ST_RUN;
                    end else begin
                        w_next_state = ST_FAULT;
                    end
                end else if (i_trap_req) begin
                    w_next_pend_valid  = 1'b1;
                    w_next_pend_target = w_trap_tgt;
                end
            end
            ST_FAULT: begin
                w_next_pend_valid = 1'b0;
                if (i_trap_req) begin
                    w_next_addr  = w_trap_tgt;
                    w_next_state = ST_RUN;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state          <= ST_IDLE;
            r_fetch_addr     <= RESET_VECTOR;
            r_pend_valid     <= 1'b0;
            r_pend_target    <= '0;
            r_misalign_fault <= 1'b0;
        end else begin
            r_state          <= w_next_state;
            r_fetch_addr     <= w_next_addr;
            r_pend_valid     <= w_next_pend_valid;
            r_pend_target    <= w_next_pend_target;
            r_misalign_fault <= w_misalign;
        end
    end

    assign o_fetch_addr       = r_fetch_addr;
    assign o_fetch_valid      = w_fetch_valid;
    assign o_pc_link          = r_fetch_addr + PC_STEP;
    assign o_redirect_pending = r_pend_valid;
    assign o_misalign_fault   = r_misalign_fault;

endmodule

// File: tb/tb_risc_pc_unit.sv
// tb/tb_risc_pc_unit.sv - directed self-checking bench for risc_pc_unit
module tb_risc_pc_unit;

    logic        clk;
    logic        rst;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] pc_link;
    logic        br_taken;
    logic [31:0] br_offset;
    logic        jr_taken;
    logic [31:0] jr_target;
    logic        trap_req;
    logic [31:0] trap_vector;
    logic        redirect_pending;
    logic        misalign_fault;

    int total = 0;
    int bad   = 0;

    risc_pc_unit #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0),
        .OFFSET_SHIFT (1),
        .ALIGN_BYTES  (4)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .o_fetch_addr       (fetch_addr),
        .o_fetch_valid      (fetch_valid),
        .i_fetch_ready      (fetch_ready),
        .o_pc_link          (pc_link),
        .i_br_taken         (br_taken),
        .i_br_offset        (br_offset),
        .i_jr_taken         (jr_taken),
        .i_jr_target        (jr_target),
        .i_trap_req         (trap_req),
        .i_trap_vector      (trap_vector),
        .o_redirect_pending (redirect_pending),
        .o_misalign_fault   (misalign_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirects();
        br_taken = 1'b0; jr_taken = 1'b0; trap_req = 1'b0;
        br_offset = 32'h0; jr_target = 32'h0; trap_vector = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_ready = 1'b1; clear_redirects();
        step();
        total++; if (fetch_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=%h", fetch_addr, 32'h0); end
        total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", fetch_valid); end
        total++; if (redirect_pending !== 1'b0 || misalign_fault !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", redirect_pending, misalign_fault); end
        rst = 1'b0;
        #1;
        total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b exp=0", fetch_valid); end
        step();
        total++; if (fetch_valid !== 1'b1 || fetch_addr !== 32'h0) begin bad++; $display("FAIL run_first got=%b/%h exp=1/00000000", fetch_valid, fetch_addr); end
        step();
        total++; if (fetch_addr !== 32'h4) begin bad++; $display("FAIL seq_4 got=%h exp=00000004", fetch_addr); end
        step();
        total++; if (fetch_addr !== 32'h8 || pc_link !== 32'hC) begin bad++; $display("FAIL seq_8 got=%h/%h exp=00000008/0000000c", fetch_addr, pc_link); end
    endtask

    task automatic test_stall_redirect();
        step();
        step();
        total++; if (fetch_addr !== 32'h10) begin bad++; $display("FAIL at_10 got=%h exp=00000010", fetch_addr); end
        fetch_ready = 1'b0; br_taken = 1'b1; br_offset = 32'h8;
        step();
        clear_redirects();
        total++; if (fetch_addr !== 32'h10 || redirect_pending !== 1'b1) begin bad++; $display("FAIL stall_hold got=%h/%b exp=00000010/1", fetch_addr, redirect_pending); end
        step();
        step();
        total++; if (fetch_addr !== 32'h10 || fetch_valid !== 1'b1) begin bad++; $display("FAIL stall_hold3 got=%h/%b exp=00000010/1", fetch_addr, fetch_valid); end
        fetch_ready = 1'b1;
        step();
        total++; if (fetch_addr !== 32'h20 || redirect_pending !== 1'b0) begin bad++; $display("FAIL pend_apply got=%h/%b exp=00000020/0", fetch_addr, redirect_pending); end
    endtask

    task automatic test_priority();
        trap_req = 1'b1; trap_vector = 32'h103;
        jr_taken = 1'b1; jr_target = 32'h555;
        br_taken = 1'b1; br_offset = 32'h3;
        step();
        clear_redirects();
        total++; if (fetch_addr !== 32'h100 || misalign_fault !== 1'b0) begin bad++; $display("FAIL trap_prio got=%h/%b exp=00000100/0", fetch_addr, misalign_fault); end
    endtask

    task automatic test_misalign();
        jr_taken = 1'b1; jr_target = 32'h1001;
        step();
        clear_redirects();
        total++; if (fetch_addr !== 32'h1000 || misalign_fault !== 1'b0) begin bad++; $display("FAIL jr_bit0 got=%h/%b exp=00001000/0", fetch_addr, misalign_fault); end
        jr_taken = 1'b1; jr_target = 32'h40;
        step();
        clear_redirects();
        total++; if (fetch_addr !== 32'h40) begin bad++; $display("FAIL jr_40 got=%h exp=00000040", fetch_addr); end
        br_taken = 1'b1; br_offset = 32'h1;
        step();
        clear_redirects();
        total++; if (misalign_fault !== 1'b1 || fetch_valid !== 1'b0) begin bad++; $display("FAIL br_misalign got=%b/%b exp=1/0", misalign_fault, fetch_valid); end
        br_taken = 1'b1; br_offset = 32'h10;
        step();
        clear_redirects();
        total++; if (misalign_fault !== 1'b0 || fetch_valid !== 1'b0) begin bad++; $display("FAIL fault_park got=%b/%b exp=0/0", misalign_fault, fetch_valid); end
        trap_req = 1'b1; trap_vector = 32'h200;
        step();
        clear_redirects();
        total++; if (fetch_addr !== 32'h200 || fetch_valid !== 1'b1) begin bad++; $display("FAIL trap_exit got=%h/%b exp=00000200/1", fetch_addr, fetch_valid); end
    endtask

    task automatic test_drain();
        fetch_ready = 1'b0; br_taken = 1'b1; br_offset = 32'h1;
        step();
        clear_redirects();
        total++; if (misalign_fault !== 1'b1 || fetch_valid !== 1'b1 || fetch_addr !== 32'h200) begin bad++; $display("FAIL drain_enter got=%b/%b/%h exp=1/1/00000200", misalign_fault, fetch_valid, fetch_addr); end
        trap_req = 1'b1; trap_vector = 32'h302;
        step();
        clear_redirects();
        total++; if (redirect_pending !== 1'b1 || misalign_fault !== 1'b0) begin bad++; $display("FAIL drain_buf got=%b/%b exp=1/0", redirect_pending, misalign_fault); end
        fetch_ready = 1'b1;
        step();
        total++; if (fetch_addr !== 32'h300 || fetch_valid !== 1'b1 || redirect_pending !== 1'b0) begin bad++; $display("FAIL drain_trap got=%h/%b/%b exp=00000300/1/0", fetch_addr, fetch_valid, redirect_pending); end
    endtask

    task automatic test_wrap();
        jr_taken = 1'b1; jr_target = 32'hFFFF_FFFC;
        step();
        clear_redirects();
        total++; if (fetch_addr !== 32'hFFFF_FFFC || pc_link !== 32'h0) begin bad++; $display("FAIL pre_wrap got=%h/%h exp=fffffffc/00000000", fetch_addr, pc_link); end
        step();
        total++; if (fetch_addr !== 32'h0) begin bad++; $display("FAIL wrap got=%h exp=00000000", fetch_addr); end
    endtask

    task automatic test_async_reset();
        step();
        step();
        fetch_ready = 1'b0; br_taken = 1'b1; br_offset = 32'h20;
        step();
        clear_redirects();
        total++; if (redirect_pending !== 1'b1 || fetch_addr !== 32'h8) begin bad++; $display("FAIL pre_rst got=%b/%h exp=1/00000008", redirect_pending, fetch_addr); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (fetch_addr !== 32'h0 || fetch_valid !== 1'b0 || redirect_pending !== 1'b0) begin bad++; $display("FAIL async_rst got=%h/%b/%b exp=00000000/0/0", fetch_addr, fetch_valid, redirect_pending); end
        step();
        rst = 1'b0;
        fetch_ready = 1'b1;
        step();
        total++; if (fetch_addr !== 32'h0 || fetch_valid !== 1'b1) begin bad++; $display("FAIL post_rst got=%h/%b exp=00000000/1", fetch_addr, fetch_valid); end
    endtask

    initial begin
        test_reset();
        test_stall_redirect();
        test_priority();
        test_misalign();
        test_drain();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
